// File: rtl/alu_arb_pkg.sv
// Shared types and encodings for the two-requester shared-ALU arbiter.
// Holds the FSM states, ALU op-codes, NZVC bit indices and the latched-operation record.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        sf;
    logic        id;
  } op_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-input round-robin grant: a lone requester wins outright, a tie goes to rr_ptr.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between EX and address-gen: accept, hold operands SETTLE_CYCLES, capture, respond.
// Response after SETTLE_CYCLES edges; rsp held until rsp_ready, and no accepts outside IDLE.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][63:0] req_a,
  input  logic [1:0][63:0] req_b,
  input  logic [1:0][2:0]  req_op,
  input  logic [1:0]       req_sf,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [63:0]      alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [63:0]      rsp_result,
  input  logic             rsp_ready,
  output logic [3:0]       flags
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_arbiter: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic [3:0]  flags_q, flags_d;

  logic [1:0]  gnt;
  logic        gnt_id;
  logic        accept;

  rr_arbiter2 u_rr_arbiter2 (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt)
  );

  assign gnt_id    = gnt[1];
  // Gating with reset_n keeps req_ready low while reset is still being applied.
  assign req_ready = (reset_n && state_q == IDLE) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EXEC;
          rr_ptr_d = ~gnt_id;
          cnt_d    = SETTLE_LD;
          op_d     = '{a: req_a[gnt_id], b: req_b[gnt_id], op: req_op[gnt_id],
                       sf: req_sf[gnt_id], id: gnt_id};
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          // Illegal op-codes still respond, but with a zero result and no flag update.
          rsp_result_d = op_legal(op_q.op) ? alu_result : 64'd0;
          if (op_legal(op_q.op) && op_q.sf) begin
            flags_d = alu_flags;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      cnt_q        <= 4'd0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 64'd0;
      flags_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      flags_q      <= flags_d;
    end
  end

  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_cntrl  = op_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = op_q.id;
  assign rsp_result = rsp_result_q;
  assign flags      = flags_q;

endmodule
